shift_reg_univ: RTL and testbench

- Parametrised universal shift register; successor to the 4-bit fixed SISO stage.
- Supports hold, shift-right, shift-left and parallel load, with serial and parallel outputs.
- Built-in shift counter flags when a full word has been shifted since the last load or reset.
- Used as a SISO/SIPO/PISO/PIPO building block in serial links and bit-serial test fixtures.

---
 rtl/shift_reg_pkg.sv | 15 +
 rtl/shift_cnt_sat.sv | 54 +++++
 rtl/shift_reg_univ.sv | 86 ++++++++
 tb/tb_shift_reg_univ.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register.
//   MODE_*     : encodings of the 2-bit mode input
//   cnt_width  : bits needed to hold a shift count from 0 up to the word width
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_cnt_sat.sv
// Saturating up-counter with synchronous clear and a terminal-count pulse.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : forces the count to zero and suppresses the pulse
//   inc      : advance by one unless already at MAX
//   cnt_o    : current count, 0..MAX
//   tc_o     : registered one-cycle pulse after the count reaches MAX
module shift_cnt_sat
    import shift_reg_pkg::*;
#(
    parameter int MAX   = 4,
    parameter int CNT_W = cnt_width(MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q,  tc_d;

    // The pulse only fires on the increment that lands on MAX, so increments
    // while already saturated leave it low until a clear re-arms the count.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + ONE_C;
            tc_d  = (cnt_q == (MAX_C - ONE_C));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, plus a saturating count of shifts since the last load/reset.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   en                : clock enable; low freezes register and count
//   mode              : 00 hold, 01 shift right, 10 shift left, 11 load
//   sin_msb, sin_lsb  : serial inputs for shift right / shift left
//   pin               : parallel load data
//   pout              : register contents
//   sout_lsb, sout_msb: serial outputs (q[0], q[WIDTH-1])
//   cnt               : shifts since last load/reset, saturating at WIDTH
//   done              : one-cycle pulse when cnt reaches WIDTH
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             shift_s;
    logic             load_s;

    always_comb begin
        q_d     = q_q;
        shift_s = 1'b0;
        load_s  = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    q_d     = {sin_msb, q_q[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], sin_lsb};
                    shift_s = 1'b1;
                end
                MODE_LOAD: begin
                    q_d    = pin;
                    load_s = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // Direction does not matter to the counter: every shift edge counts.
    shift_cnt_sat #(
        .MAX   (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (load_s),
        .inc   (shift_s),
        .cnt_o (cnt),
        .tc_o  (done)
    );

    assign pout     = q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

    localparam int W  = 4;
    localparam int CW = 3;
    localparam logic [W-1:0] RV2 = 4'b1010;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         sin_msb = 1'b0;
    logic         sin_lsb = 1'b0;
    logic [W-1:0] pin = '0;

    logic [W-1:0]  pout,  pout2;
    logic          sout_lsb, sout_msb, sout_lsb2, sout_msb2;
    logic [CW-1:0] cnt,   cnt2;
    logic          done,  done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .pin(pin),
        .pout(pout), .sout_lsb(sout_lsb), .sout_msb(sout_msb),
        .cnt(cnt), .done(done)
    );

    shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV2)) dut_rv (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .pin(pin),
        .pout(pout2), .sout_lsb(sout_lsb2), .sout_msb(sout_msb2),
        .cnt(cnt2), .done(done2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: register value as an integer, shifts counted without bound since
    // the last load/reset; cnt is the count clipped to W, done fires on the
    // edge where the count becomes exactly W.
    int m_q, m_q2, m_shifts, m_done;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q = 0; m_q2 = int'(RV2); m_shifts = 0; m_done = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 0;
            if (en) begin
                if (mode == 2'b01) begin
                    m_q  = m_q / 2  + int'(sin_msb) * (2 ** (W - 1));
                    m_q2 = m_q2 / 2 + int'(sin_msb) * (2 ** (W - 1));
                    m_shifts++;
                    if (m_shifts == W) m_done = 1;
                end else if (mode == 2'b10) begin
                    m_q  = (m_q * 2  + int'(sin_lsb)) % (2 ** W);
                    m_q2 = (m_q2 * 2 + int'(sin_lsb)) % (2 ** W);
                    m_shifts++;
                    if (m_shifts == W) m_done = 1;
                end else if (mode == 2'b11) begin
                    m_q = int'(pin); m_q2 = int'(pin); m_shifts = 0;
                end
            end
        end
        #1;
        if (m_valid) begin
            chk("m_pout",  int'(pout),  m_q);
            chk("m_lsb",   int'(sout_lsb), m_q % 2);
            chk("m_msb",   int'(sout_msb), m_q / (2 ** (W - 1)));
            chk("m_cnt",   int'(cnt),   (m_shifts < W) ? m_shifts : W);
            chk("m_done",  int'(done),  m_done);
            chk("m_pout2", int'(pout2), m_q2);
            chk("m_cnt2",  int'(cnt2),  (m_shifts < W) ? m_shifts : W);
            chk("m_done2", int'(done2), m_done);
        end
    end

    task automatic tick(input logic r, input logic e, input logic [1:0] m,
                        input logic sm, input logic sl, input logic [W-1:0] p);
        @(negedge clk);
        rst = r; en = e; mode = m; sin_msb = sm; sin_lsb = sl; pin = p;
        @(posedge clk);
        #2;
    endtask

    task automatic shr(input logic b);
        tick(1'b0, 1'b1, 2'b01, b, 1'b0, '0);
    endtask

    task automatic shl(input logic b);
        tick(1'b0, 1'b1, 2'b10, 1'b0, b, '0);
    endtask

    task automatic load(input logic [W-1:0] p);
        tick(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, p);
    endtask

    logic [W-1:0] saved;
    logic [3:0]   siso_bits;
    logic [3:0]   msb_exp;

    initial begin
        // reset
        tick(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 4'b1111);
        chk("rst_pout", int'(pout), 0);
        chk("rst_cnt",  int'(cnt), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rv",   int'(pout2), 10);

        // legacy SISO right: 1,0,0,1
        siso_bits = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            shr(siso_bits[3 - i]);
            if (i < 3) chk("siso_done_early", int'(done), 0);
        end
        chk("siso_pout", int'(pout), 9);
        chk("siso_lsb",  int'(sout_lsb), 1);
        chk("siso_cnt",  int'(cnt), 4);
        chk("siso_done", int'(done), 1);
        tick(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, '0);
        chk("siso_done_once", int'(done), 0);

        // PISO left from 1101
        load(4'b1101);
        chk("piso_cnt0", int'(cnt), 0);
        msb_exp = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            chk("piso_msb", int'(sout_msb), int'(msb_exp[3 - i]));
            shl(1'b0);
        end
        chk("piso_pout", int'(pout), 0);
        chk("piso_done", int'(done), 1);
        shl(1'b1);
        chk("piso_no_repulse", int'(done), 0);

        // saturation and re-arm
        load(4'b0110);
        for (int i = 1; i <= 6; i++) begin
            shr(1'b1);
            chk("sat_cnt",  int'(cnt), (i < 4) ? i : 4);
            chk("sat_done", int'(done), (i == 4) ? 1 : 0);
        end
        load(4'b0011);
        chk("rearm_cnt", int'(cnt), 0);
        for (int i = 1; i <= 4; i++) shl(1'b1);
        chk("rearm_done", int'(done), 1);

        // enable low and hold mid-word
        load(4'b1001);
        shr(1'b0);
        shr(1'b1);
        saved = pout;
        chk("hold_cnt2", int'(cnt), 2);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 4'b1111);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'b1111);
        chk("hold_pout", int'(pout), int'(saved));
        chk("hold_cnt",  int'(cnt), 2);
        chk("hold_done", int'(done), 0);
        shl(1'b1);
        chk("resume_done_early", int'(done), 0);
        shr(1'b0);
        chk("resume_done", int'(done), 1);

        // reset mid-operation
        load(4'b0101);
        shr(1'b1); shr(1'b1); shr(1'b1);
        chk("mid_cnt3", int'(cnt), 3);
        tick(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, '0);
        chk("mid_rst_cnt",  int'(cnt), 0);
        chk("mid_rst_pout", int'(pout), 0);
        chk("mid_rst_rv",   int'(pout2), 10);
        chk("mid_rst_done", int'(done), 0);
        for (int i = 1; i <= 4; i++) begin
            shr(1'b1);
            chk("post_rst_done", int'(done), (i == 4) ? 1 : 0);
        end
        chk("post_rst_pout", int'(pout), 15);

        // mixed directions checked by the model alone
        siso_bits = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            if (i[0]) shl(siso_bits[i % 4]);
            else      shr(~siso_bits[i % 4]);
        end
        load(4'b1110);
        tick(1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 4'b0001);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
